// File: rtl/regression_sample_source_pkg.sv
// Shared constants and FSM encoding for the regression sample source and its
// downstream error checker.
package regression_sample_source_pkg;

    localparam int DEF_N_SAMPLES = 150;
    localparam int DEF_DATA_W    = 20;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_HOLD      = 2;
    localparam int DEF_GAP       = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_COLLECT = 3'd4,
        ST_DONE    = 3'd5
    } src_state_t;

endpackage

// File: rtl/regression_sample_source_ram.sv
// Sample-pair storage: one synchronous write port, one synchronous read port.
// Contents are deliberately not reset.
module sample_pair_ram
    import regression_sample_source_pkg::*;
#(
    parameter int DEPTH = DEF_N_SAMPLES,
    parameter int WIDTH = 2 * DEF_DATA_W,
    parameter int AW    = DEF_ADDR_W
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/regression_sample_source.sv
// Streams stored (x, y) pairs to the error checker, then collects its per-sample
// errors and reports the sum and maximum of their absolute values.
module regression_sample_source
    import regression_sample_source_pkg::*;
#(
    parameter int N_SAMPLES = DEF_N_SAMPLES,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int HOLD      = DEF_HOLD,
    parameter int GAP       = DEF_GAP
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_x,
    input  logic [DATA_W-1:0]   wr_y,
    input  logic                start,
    input  logic [DATA_W-1:0]   error_in,
    output logic                en,
    output logic [DATA_W-1:0]   x_bus,
    output logic [DATA_W-1:0]   y_bus,
    output logic                busy,
    output logic                done,
    output logic [DATA_W+7:0]   sum_abs_err,
    output logic [DATA_W-1:0]   max_abs_err
);

    localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP - 1);

    src_state_t          state;
    logic [ADDR_W-1:0]   idx;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   rd_addr;
    logic [2*DATA_W-1:0] rd_data;
    logic                wr_ok;
    logic [DATA_W-1:0]   err_abs;

    // Memory is writable only while idle, so a write never races a stream read.
    always_comb wr_ok = (state == ST_IDLE) && wr_en && (wr_addr <= LAST_IDX);

    // Read one pair ahead: IDLE keeps pair 0 ready for the ARM->SEND edge, and
    // during SEND the next pair lands mid-window. This needs HOLD >= 2.
    always_comb begin
        rd_addr = '0;
        if ((state == ST_ARM || state == ST_SEND) && idx != LAST_IDX)
            rd_addr = idx + ADDR_W'(1);
    end

    // Two's complement magnitude; the most negative word maps to 2^(DATA_W-1).
    always_comb err_abs = error_in[DATA_W-1] ? (~error_in + DATA_W'(1)) : error_in;

    sample_pair_ram #(
        .DEPTH (N_SAMPLES),
        .WIDTH (2 * DATA_W),
        .AW    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data ({wr_x, wr_y}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            cnt         <= '0;
            en          <= 1'b0;
            x_bus       <= '0;
            y_bus       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
        end else begin
            en   <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_ARM;
                        en          <= 1'b1;
                        busy        <= 1'b1;
                        idx         <= '0;
                        sum_abs_err <= '0;
                        max_abs_err <= '0;
                    end
                end
                ST_ARM: begin
                    state          <= ST_SEND;
                    {x_bus, y_bus} <= rd_data;
                    idx            <= '0;
                    cnt            <= HOLD_LOAD;
                end
                ST_SEND: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (idx == LAST_IDX) begin
                        state <= ST_WAIT;
                        x_bus <= '0;
                        y_bus <= '0;
                        cnt   <= GAP_LOAD;
                    end else begin
                        idx            <= idx + ADDR_W'(1);
                        {x_bus, y_bus} <= rd_data;
                        cnt            <= HOLD_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= ST_COLLECT;
                        idx   <= '0;
                        cnt   <= HOLD_LOAD;
                    end
                end
                ST_COLLECT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // Final edge of the window: take this sample.
                        sum_abs_err <= sum_abs_err + {8'd0, err_abs};
                        if (err_abs > max_abs_err)
                            max_abs_err <= err_abs;
                        cnt <= HOLD_LOAD;
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            idx <= idx + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/regression_sample_source.md
# regression_sample_source

Producer side of the regression error-checking path. Holds up to 150 (x, y) sample pairs written by the host and, on `start`, pulses `en` and streams the pairs in index order onto `x_bus`/`y_bus` for the downstream error checker. It then collects the checker's per-sample `error_in` stream and reports the sum and the maximum of the absolute errors, with a one-cycle `done` strobe.

## Interface
- `N_SAMPLES`, 150: number of pairs streamed and errors collected.
- `DATA_W`, 20: width of x, y and error words. Error words are two's complement.
- `ADDR_W`, 8: sample index width; must satisfy 2^ADDR_W ≥ N_SAMPLES.
- `HOLD`, 2: cycles each pair is held on the bus, and the spacing between error samples.
- `GAP`, 2: idle cycles between the send phase and the collect phase.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state except sample memory.
- `wr_en`  in  1  host write strobe for sample memory.
- `wr_addr`  in  ADDR_W  write index, 0..N_SAMPLES-1.
- `wr_x`, `wr_y`  in  DATA_W  sample pair to store.
- `start`  in  1  begin one stream/collect run.
- `error_in`  in  DATA_W  error word from the checker.
- `en`  out  1  one-cycle enable pulse to the checker.
- `x_bus`, `y_bus`  out  DATA_W  streamed sample pair.
- `busy`  out  1  high from the ARM state through COLLECT.
- `done`  out  1  one-cycle strobe; results valid.
- `sum_abs_err`  out  DATA_W+8  sum of |error_in| over N_SAMPLES.
- `max_abs_err`  out  DATA_W  maximum |error_in|.

## Operation
- **FSM states:** IDLE → ARM → SEND → WAIT → COLLECT → DONE → IDLE.
- **IDLE**
  - `wr_en` with `wr_addr` < N_SAMPLES writes the pair to memory.
  - Writes with an out-of-range address, or while `busy`, are ignored.
  - `start`=1 goes to ARM. The accumulators clear on this transition.
- **ARM:** `en`=1 for exactly this cycle; buses are 0.
- **SEND**
  - The index runs 0..N_SAMPLES-1, and each pair is driven for HOLD cycles.
  - `x_bus`/`y_bus` are registered outputs.
  - After the last pair, go to WAIT. Buses return to 0.
- **WAIT:** GAP cycles, then COLLECT.
- **COLLECT**
  - N_SAMPLES windows of HOLD cycles each.
  - `error_in` is sampled on the final edge of each window.
  - abs = negated value if the MSB is set. −2^(DATA_W−1) maps to 2^(DATA_W−1), which fits unsigned DATA_W.
  - `sum_abs_err` += abs; `max_abs_err` = max(current, abs).
  - Sum width DATA_W+8 cannot overflow for N_SAMPLES ≤ 256.
- **DONE:** `done`=1 for one cycle, then IDLE. Results hold until the next `start`.
- **Ignored inputs:** `start` while `busy` or in DONE is ignored. `wr_en` during a run is ignored.
- **Reset:**
  - Any state returns to IDLE.
  - All outputs go to 0: `en`, `x_bus`, `y_bus`, `busy`, `done`, `sum_abs_err`, `max_abs_err`.
  - Sample memory is not reset and retains its contents.

## Timing
Edge E0 is the edge that samples `start`=1.
- ARM occupies E0→E1.
- Pair k is on the bus from edge E1+k·HOLD to E1+(k+1)·HOLD.
- WAIT runs E1+N·HOLD → E1+N·HOLD+GAP.
- Error k is sampled at edge E1+N·HOLD+GAP+(k+1)·HOLD.
- `done` rises at edge E1+2·N·HOLD+GAP. With defaults this is E603.
- `busy` is high from E0 through the edge at which `done` rises.
- A write and a read of the same address never coincide, because writes are blocked while busy.

## Structure
- **Shared package:** DATA_W, N_SAMPLES, ADDR_W defaults and the FSM state encoding (3-bit: IDLE=0, ARM=1, SEND=2, WAIT=3, COLLECT=4, DONE=5). The downstream checker uses the same constants.
- **Sub-module `sample_pair_ram`**
  - N_SAMPLES × 2·DATA_W.
  - One synchronous write port and one synchronous read port.
  - The read address is pre-issued one cycle early so the bus registers update on the window boundary.
- **Top level:** FSM, index counter, HOLD/GAP down-counter, abs/accumulate/max datapath.

## Test plan
- **Reset values:** `reset`=0 mid-SEND at pair 40.
  - All outputs read 0 and the state is IDLE.
  - A new `start` streams from pair 0 and earlier writes are intact.
- **Full run:** write x=k, y=3k+5 for k=0..149; start; return `error_in`=k−75 each window.
  - `en` is high for 1 cycle at E0→E1.
  - Pair 37 is on the bus during E75–E77.
  - `done` at E603; `sum_abs_err`=5625; `max_abs_err`=75.
- **Extreme error:** `error_in` fixed at 20'h80000.
  - `max_abs_err`=524288; `sum_abs_err`=78643200.
- **Ignored start:** `start` pulses at E10 and at the DONE cycle.
  - No restart and no second `en` pulse.
  - Results unchanged and `busy` drops after DONE.
- **Blocked and out-of-range writes:** `wr_en` during SEND at address 5, and `wr_addr`=200 in IDLE.
  - Memory is unchanged; the next run streams the original pair 5.
